rr_packed_logb_gearbox: RTL and testbench
=========================================

RR_PACKED_LOGB_GEARBOX -- requirements
Module: rr_packed_logb_gearbox

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 1024, the packed logb data width of the merge-tree output.
REQ-002 SHALL have parameter OUT_WIDTH, default 512, the fixed word width delivered to the trace writer.
REQ-003 SHALL have parameter CAP_BITS, default 8192, the accumulator capacity in bits.
REQ-004 SHALL have parameter ALMFUL_MARGIN, default 4096, the free-bit threshold for almful.
REQ-005 SHALL use one clock with synchronous, active-high reset: clk input 1 is the clock; rst input 1 is the reset.
REQ-006 SHALL have port in_valid, input, 1 bit: packed bus any_valid.
REQ-007 SHALL have port in_data, input, IN_WIDTH bits: packed bits, LSB-first, meaningful below in_len.
REQ-008 SHALL have port in_len, input, $clog2(IN_WIDTH+1) bits: valid bit count.
REQ-009 SHALL have port almful, output, 1 bit: back-pressure to the upstream logb_almful pipe.
REQ-010 SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: the output handshake.
REQ-011 SHALL have port out_data, output, OUT_WIDTH bits: output word.
REQ-012 SHALL have port out_last, output, 1 bit: marks the final (padded) word of a flush.
REQ-013 SHALL have port flush_req, input, 1 bit, a single-cycle request, and port flush_done, output, 1 bit, a single-cycle completion pulse.
REQ-014 SHALL have port fill, output, $clog2(CAP_BITS+1) bits: current accumulated bit count.
REQ-015 SHALL have port words_out, output, 32 bits: count of completed output handshakes.
REQ-016 SHALL have port err_overflow, output, 1 bit: sticky error flag.

Function
REQ-017 The input has no ready signal; a beat counts as accepted when in_valid=1 and in_len>0. An in_valid=1 beat with in_len=0 is a no-op.
REQ-018 Accepted bits are appended at bit position fill of the accumulator; earlier bits always occupy lower positions.
REQ-019 out_data SHALL equal accumulator bits [OUT_WIDTH-1:0], driven from registered state only. There is no combinational path from in_* to out_*.
REQ-020 In state RUN, out_valid=1 iff fill>=OUT_WIDTH.
REQ-021 When out_valid=1 and out_ready=1, the accumulator shifts down by OUT_WIDTH and words_out increments; words_out wraps modulo 2^32.
REQ-022 When a pop and an append occur in the same cycle, next fill = fill - OUT_WIDTH + in_len. The appended bits land at position fill-OUT_WIDTH of the shifted accumulator.
REQ-023 Latency: the earliest cycle an accepted bit can appear on out_data is the cycle after acceptance.
REQ-024 out_data and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 almful=1 iff the registered fill > CAP_BITS-ALMFUL_MARGIN.
REQ-026 Overflow: if fill(after pop)+in_len > CAP_BITS, the whole beat is dropped, fill is unchanged by it, and err_overflow is set until reset.
REQ-027 The FSM has states RUN, FLUSH and PAD. It resets to RUN.
REQ-028 RUN->FLUSH on flush_req=1. flush_req received while in FLUSH or PAD is ignored.
REQ-029 In FLUSH, full words drain as in REQ-020/021, and input continues to be appended.
REQ-030 FLUSH->PAD when fill<OUT_WIDTH, fill>0 and in_valid=0.
REQ-031 FLUSH->RUN with flush_done=1 for one cycle when fill=0 and in_valid=0.
REQ-032 In PAD, out_valid=1 and out_last=1. out_data has bits at or above fill forced to 0.
REQ-033 In PAD, on handshake, fill becomes 0, flush_done pulses in that cycle, and the FSM goes to RUN.
REQ-034 Any in_valid beat accepted in PAD is appended above the padding boundary and is emitted after the padded word.
REQ-035 out_last=0 outside PAD.

Reset
REQ-036 While rst=1 at a clk edge: fill=0, FSM=RUN, words_out=0, err_overflow=0.
REQ-037 During and after reset: out_valid=0, out_last=0, flush_done=0, almful=0.
REQ-038 Accumulator contents are not reset. Simulation drives them to zero under SIMULATION_AVOID_X.
REQ-039 Reset asserted mid-flush discards all buffered bits without emitting a padded word.

Structure
REQ-040 The FSM state enum, the default widths and the error-bit typedef SHALL live in the shared rr packing package next to PACKET_ALIGNMENT.
REQ-041 The variable-offset append shifter SHALL be a sub-module, rr_bit_append_shifter, with no state of its own.
REQ-042 in_len and OUT_WIDTH SHALL be multiples of PACKET_ALIGNMENT, so the shifter operates at PACKET_ALIGNMENT granularity; elaboration errors otherwise.

Verification (OUT_WIDTH=512, IN_WIDTH=1024, CAP_BITS=8192)
REQ-043 Two beats of len 256 (0xAA.., then 0x55..) with out_ready=1 -> one word, low half 0xAA.., high half 0x55.., words_out=1, fill=0.
REQ-044 One beat of len 1024 with out_ready=1 -> two consecutive output words; the second word is popped in the cycle after the first.
REQ-045 out_ready=0 and 9 beats of len 1024 -> almful rises once fill>4096, 9th beat dropped, err_overflow=1, fill=8192.
REQ-046 Beat of len 200, then flush_req -> PAD word with bits [511:200]=0, out_last=1, flush_done pulse, FSM back to RUN.
REQ-047 A 512-bit pop and a len-256 append in the same cycle with fill=600 -> next fill=344, and the new data starts at bit 88.
REQ-048 rst=1 during PAD with out_ready=0 -> next cycle out_valid=0, fill=0, no out_last ever seen.

Source files
------------

// File: rtl/rr_packed_logb_gearbox_pkg.sv
// Shared rr packing definitions: alignment granule, default widths, gearbox FSM states
// and the error-bit type.
package rr_packed_logb_gearbox_pkg;

    localparam int unsigned PACKET_ALIGNMENT = 8;

    localparam int unsigned DEF_IN_WIDTH      = 1024;
    localparam int unsigned DEF_OUT_WIDTH     = 512;
    localparam int unsigned DEF_CAP_BITS      = 8192;
    localparam int unsigned DEF_ALMFUL_MARGIN = 4096;

    typedef enum logic [1:0] {
        StRun,
        StFlush,
        StPad
    } gb_state_e;

    typedef struct packed {
        logic overflow;
    } rr_err_t;

    function automatic bit is_aligned(int unsigned w);
        return (w % PACKET_ALIGNMENT) == 0;
    endfunction

endpackage

// File: rtl/rr_bit_append_shifter.sv
// Stateless merge: keeps accumulator bits below off and places the low len bits of data
// starting at off. Offset and length are taken at PACKET_ALIGNMENT granularity.
module rr_bit_append_shifter
    import rr_packed_logb_gearbox_pkg::*;
#(
    parameter int unsigned IN_WIDTH = DEF_IN_WIDTH,
    parameter int unsigned CAP_BITS = DEF_CAP_BITS
) (
    input  logic [CAP_BITS-1:0]              acc,
    input  logic [$clog2(CAP_BITS+1)-1:0]    off,
    input  logic [IN_WIDTH-1:0]              data,
    input  logic [$clog2(IN_WIDTH+1)-1:0]    len,
    output logic [CAP_BITS-1:0]              merged
);

    localparam int unsigned LEN_W = $clog2(IN_WIDTH + 1);
    localparam int unsigned OFF_W = $clog2(CAP_BITS + 1);

    logic [LEN_W-1:0]    len_al;
    logic [OFF_W-1:0]    off_al;
    logic [IN_WIDTH-1:0] data_m;
    logic [CAP_BITS-1:0] data_ext;
    logic [CAP_BITS-1:0] keep;

    always_comb begin
        len_al   = len & ~LEN_W'(PACKET_ALIGNMENT - 1);
        off_al   = off & ~OFF_W'(PACKET_ALIGNMENT - 1);
        data_m   = data & ~({IN_WIDTH{1'b1}} << len_al);
        data_ext = {{(CAP_BITS - IN_WIDTH){1'b0}}, data_m};
        // Clearing everything at and above off keeps stale high bits out of later words.
        keep     = ~({CAP_BITS{1'b1}} << off_al);
        merged   = (acc & keep) | (data_ext << off_al);
    end

endmodule

// File: rtl/rr_packed_logb_gearbox.sv
// Variable-length packed logb bit stream to fixed OUT_WIDTH words, with flush/pad of the
// trailing partial word.
module rr_packed_logb_gearbox
    import rr_packed_logb_gearbox_pkg::*;
#(
    parameter int unsigned IN_WIDTH      = DEF_IN_WIDTH,
    parameter int unsigned OUT_WIDTH     = DEF_OUT_WIDTH,
    parameter int unsigned CAP_BITS      = DEF_CAP_BITS,
    parameter int unsigned ALMFUL_MARGIN = DEF_ALMFUL_MARGIN
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [IN_WIDTH-1:0]             in_data,
    input  logic [$clog2(IN_WIDTH+1)-1:0]   in_len,
    output logic                            almful,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [OUT_WIDTH-1:0]            out_data,
    output logic                            out_last,
    input  logic                            flush_req,
    output logic                            flush_done,
    output logic [$clog2(CAP_BITS+1)-1:0]   fill,
    output logic [31:0]                     words_out,
    output logic                            err_overflow
);

    localparam int unsigned LEN_W  = $clog2(IN_WIDTH + 1);
    localparam int unsigned FILL_W = $clog2(CAP_BITS + 1);
    localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_WIDTH);
    localparam logic [FILL_W-1:0] CAP_F   = FILL_W'(CAP_BITS);
    localparam logic [FILL_W-1:0] ALM_F   = FILL_W'(CAP_BITS - ALMFUL_MARGIN);

    if (!is_aligned(OUT_WIDTH) || !is_aligned(IN_WIDTH) || CAP_BITS <= IN_WIDTH ||
        CAP_BITS < OUT_WIDTH || ALMFUL_MARGIN > CAP_BITS) begin : g_bad_params
        $error("rr_packed_logb_gearbox: illegal width/alignment parameters");
    end

    gb_state_e           state_q, state_d;
    logic [FILL_W-1:0]   fill_q, fill_d, fill_ap;
    logic [CAP_BITS-1:0] acc_q, acc_d, acc_sh;
    logic [31:0]         words_q, words_d;
    rr_err_t             err_q, err_d;
    logic                pop, accept, fits, done;
    logic [FILL_W:0]     sum;
    logic [LEN_W-1:0]    app_len;

    assign out_data     = acc_q[OUT_WIDTH-1:0];
    assign out_valid    = ~rst & ((state_q == StPad) || (fill_q >= OUT_W_F));
    assign out_last     = ~rst & (state_q == StPad);
    assign almful       = ~rst & (fill_q > ALM_F);
    assign flush_done   = ~rst & done;
    assign fill         = fill_q;
    assign words_out    = words_q;
    assign err_overflow = err_q.overflow;

    always_comb begin
        pop     = out_valid & out_ready;
        fill_ap = pop ? fill_q - OUT_W_F : fill_q;
        acc_sh  = pop ? (acc_q >> OUT_WIDTH) : acc_q;
        accept  = in_valid & (in_len != '0);
        sum     = {1'b0, fill_ap} + (FILL_W + 1)'(in_len);
        fits    = sum <= {1'b0, CAP_F};
        app_len = (accept & fits) ? in_len : '0;
        fill_d  = fill_ap + FILL_W'(app_len);
        words_d = words_q + 32'(pop);
        err_d   = err_q;
        if (accept & ~fits) err_d.overflow = 1'b1;

        state_d = state_q;
        done    = 1'b0;
        unique case (state_q)
            StRun: if (flush_req) state_d = StFlush;
            StFlush: begin
                if (!in_valid) begin
                    if (fill_q == '0) begin
                        state_d = StRun;
                        done    = 1'b1;
                    end else if (fill_q < OUT_W_F) begin
                        // The shifter already zeroes bits at/above fill, so the padded word
                        // is physically full; later beats append above it.
                        state_d = StPad;
                        fill_d  = OUT_W_F;
                    end
                end
            end
            StPad: begin
                if (pop) begin
                    state_d = StRun;
                    done    = 1'b1;
                end
            end
            default: state_d = StRun;
        endcase
    end

    rr_bit_append_shifter #(
        .IN_WIDTH (IN_WIDTH),
        .CAP_BITS (CAP_BITS)
    ) u_shifter (
        .acc    (acc_sh),
        .off    (fill_ap),
        .data   (in_data),
        .len    (app_len),
        .merged (acc_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            fill_q  <= '0;
            words_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            words_q <= words_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
`ifdef SIMULATION_AVOID_X
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
`else
        acc_q <= acc_d;
`endif
    end

endmodule

// File: tb/tb_rr_packed_logb_gearbox.sv
// Directed bench for rr_packed_logb_gearbox: a table of single-cycle vectors for fill,
// almful and overflow, plus hand sequences for packing order, pops, flush/pad and reset.
module tb_rr_packed_logb_gearbox;

    localparam int unsigned IW = 1024;
    localparam int unsigned OW = 512;
    localparam int unsigned CB = 8192;
    localparam int unsigned AM = 4096;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [IW-1:0]   in_data;
    logic [10:0]     in_len;
    logic            almful;
    logic            out_valid;
    logic            out_ready;
    logic [OW-1:0]   out_data;
    logic            out_last;
    logic            flush_req;
    logic            flush_done;
    logic [13:0]     fill;
    logic [31:0]     words_out;
    logic            err_overflow;

    int n_vec = 0;
    int n_err = 0;

    rr_packed_logb_gearbox #(
        .IN_WIDTH      (IW),
        .OUT_WIDTH     (OW),
        .CAP_BITS      (CB),
        .ALMFUL_MARGIN (AM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_len       (in_len),
        .almful       (almful),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .flush_req    (flush_req),
        .flush_done   (flush_done),
        .fill         (fill),
        .words_out    (words_out),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [10:0] len;
        logic        rdy;
        logic [13:0] e_fill;
        logic        e_ov;
        logic        e_alm;
        logic        e_err;
        logic [31:0] e_words;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IW-1:0] pat(input logic [7:0] b);
        return {128{b}};
    endfunction

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_data   = '0;
        in_len    = '0;
        out_ready = 1'b0;
        flush_req = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        check("rst_out_valid", OW'(out_valid), OW'(0));
        check("rst_out_last", OW'(out_last), OW'(0));
        check("rst_almful", OW'(almful), OW'(0));
        rst = 1'b0;
    endtask

    task automatic beat(input logic [7:0] b, input logic [10:0] len);
        in_valid = 1'b1;
        in_data  = pat(b);
        in_len   = len;
    endtask

    logic [OW-1:0] exp_w;
    logic [OW-1:0] held;
    logic [7:0]    b33, bcc;

    initial begin
        tbl[0]  = '{1'b1, 11'd1024, 1'b0, 14'd1024, 1'b1, 1'b0, 1'b0, 32'd0};
        tbl[1]  = '{1'b1, 11'd1024, 1'b0, 14'd2048, 1'b1, 1'b0, 1'b0, 32'd0};
        tbl[2]  = '{1'b1, 11'd1024, 1'b0, 14'd3072, 1'b1, 1'b0, 1'b0, 32'd0};
        tbl[3]  = '{1'b1, 11'd1024, 1'b0, 14'd4096, 1'b1, 1'b0, 1'b0, 32'd0};
        tbl[4]  = '{1'b1, 11'd1024, 1'b0, 14'd5120, 1'b1, 1'b1, 1'b0, 32'd0};
        tbl[5]  = '{1'b1, 11'd1024, 1'b0, 14'd6144, 1'b1, 1'b1, 1'b0, 32'd0};
        tbl[6]  = '{1'b1, 11'd1024, 1'b0, 14'd7168, 1'b1, 1'b1, 1'b0, 32'd0};
        tbl[7]  = '{1'b1, 11'd1024, 1'b0, 14'd8192, 1'b1, 1'b1, 1'b0, 32'd0};
        tbl[8]  = '{1'b1, 11'd0,    1'b0, 14'd8192, 1'b1, 1'b1, 1'b0, 32'd0};
        tbl[9]  = '{1'b1, 11'd1024, 1'b0, 14'd8192, 1'b1, 1'b1, 1'b1, 32'd0};
        tbl[10] = '{1'b0, 11'd0,    1'b1, 14'd7680, 1'b1, 1'b1, 1'b1, 32'd1};
        tbl[11] = '{1'b1, 11'd512,  1'b1, 14'd7680, 1'b1, 1'b1, 1'b1, 32'd2};

        rst = 1'b1;
        idle_inputs();
        do_reset();
        check("reset_fill", OW'(fill), OW'(0));
        check("reset_words", OW'(words_out), OW'(0));
        check("reset_err", OW'(err_overflow), OW'(0));

        // Fill to capacity with no consumer, then drain.
        for (int i = 0; i < 12; i++) begin
            in_valid  = tbl[i].v;
            in_len    = tbl[i].len;
            in_data   = pat(8'hA1);
            out_ready = tbl[i].rdy;
            step();
            check($sformatf("tbl%0d_fill", i), OW'(fill), OW'(tbl[i].e_fill));
            check($sformatf("tbl%0d_out_valid", i), OW'(out_valid), OW'(tbl[i].e_ov));
            check($sformatf("tbl%0d_almful", i), OW'(almful), OW'(tbl[i].e_alm));
            check($sformatf("tbl%0d_err", i), OW'(err_overflow), OW'(tbl[i].e_err));
            check($sformatf("tbl%0d_words", i), OW'(words_out), tbl[i].e_words);
        end

        // Two half-word beats pack into one word, earlier beat in the low half.
        do_reset();
        out_ready = 1'b1;
        beat(8'hAA, 11'd256);
        step();
        check("pack_fill1", OW'(fill), OW'(256));
        check("pack_latency", OW'(out_data[255:0]), OW'({32{8'hAA}}));
        check("pack_ov1", OW'(out_valid), OW'(0));
        beat(8'h55, 11'd256);
        step();
        in_valid = 1'b0;
        check("pack_ov2", OW'(out_valid), OW'(1));
        check("pack_word", out_data, {{32{8'h55}}, {32{8'hAA}}});
        step();
        check("pack_words", OW'(words_out), OW'(1));
        check("pack_fill_end", OW'(fill), OW'(0));
        check("pack_ov_end", OW'(out_valid), OW'(0));

        // One full-width beat yields two back-to-back words.
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_len    = 11'd1024;
        in_data   = {{64{8'h22}}, {64{8'h11}}};
        step();
        in_valid = 1'b0;
        check("two_word0", out_data, {64{8'h11}});
        check("two_ov0", OW'(out_valid), OW'(1));
        step();
        check("two_word1", out_data, {64{8'h22}});
        check("two_words1", OW'(words_out), OW'(1));
        check("two_ov1", OW'(out_valid), OW'(1));
        step();
        check("two_words2", OW'(words_out), OW'(2));
        check("two_fill2", OW'(fill), OW'(0));

        // Pop plus append in one cycle at fill=600, with a stall first.
        do_reset();
        beat(8'h33, 11'd600);
        step();
        in_valid = 1'b0;
        held = out_data;
        step();
        check("stall_data", out_data, held);
        check("stall_ov", OW'(out_valid), OW'(1));
        out_ready = 1'b1;
        beat(8'hCC, 11'd256);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("popapp_fill", OW'(fill), OW'(344));
        check("popapp_words", OW'(words_out), OW'(1));
        b33 = 8'h33;
        bcc = 8'hCC;
        for (int i = 0; i < 512; i++)
            exp_w[i] = (i < 88) ? b33[i % 8] : (i < 344) ? bcc[i % 8] : 1'b0;
        check("popapp_data", out_data, exp_w);

        // Partial word flush produces a zero-padded last word.
        do_reset();
        beat(8'hFF, 11'd200);
        step();
        in_valid  = 1'b0;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        check("flush_last_in_flush", OW'(out_last), OW'(0));
        check("flush_done_early", OW'(flush_done), OW'(0));
        step();
        exp_w = '0;
        for (int i = 0; i < 200; i++) exp_w[i] = 1'b1;
        check("pad_valid", OW'(out_valid), OW'(1));
        check("pad_last", OW'(out_last), OW'(1));
        check("pad_data", out_data, exp_w);
        out_ready = 1'b1;
        #1;
        check("pad_flush_done", OW'(flush_done), OW'(1));
        step();
        out_ready = 1'b0;
        check("pad_after_last", OW'(out_last), OW'(0));
        check("pad_after_valid", OW'(out_valid), OW'(0));
        check("pad_after_fill", OW'(fill), OW'(0));
        check("pad_after_words", OW'(words_out), OW'(1));
        check("pad_after_done", OW'(flush_done), OW'(0));

        // Flush with nothing buffered completes without a word.
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        check("empty_flush_done", OW'(flush_done), OW'(1));
        check("empty_flush_valid", OW'(out_valid), OW'(0));
        step();
        check("empty_flush_done_off", OW'(flush_done), OW'(0));

        // A beat accepted during PAD lands above the padded word.
        do_reset();
        beat(8'h0F, 11'd64);
        step();
        in_valid  = 1'b0;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        step();
        beat(8'h77, 11'd64);
        step();
        in_valid = 1'b0;
        check("padapp_word", out_data, OW'({8{8'h0F}}));
        check("padapp_last", OW'(out_last), OW'(1));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("padapp_fill", OW'(fill), OW'(64));
        check("padapp_data", OW'(out_data[63:0]), OW'({8{8'h77}}));
        check("padapp_last_off", OW'(out_last), OW'(0));

        // Reset during PAD discards the buffered bits.
        do_reset();
        beat(8'hFF, 11'd200);
        step();
        in_valid  = 1'b0;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        step();
        check("rstpad_last_before", OW'(out_last), OW'(1));
        rst = 1'b1;
        step();
        check("rstpad_valid", OW'(out_valid), OW'(0));
        check("rstpad_fill", OW'(fill), OW'(0));
        check("rstpad_last", OW'(out_last), OW'(0));
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rstpad_last_after%0d", i), OW'(out_last), OW'(0));
            check($sformatf("rstpad_valid_after%0d", i), OW'(out_valid), OW'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
